// File: rtl/ann_layer_engine.sv
// Time-multiplexed MLP engine: N_PE MAC lanes stream weights from a synchronous
// memory, run every layer through ping-pong activation buffers, then argmax the outputs.
module ann_layer_engine #(
  parameter int unsigned DW        = 8,
  parameter int unsigned FRAC      = 7,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned N_IN      = 62,
  parameter int unsigned N_HID     = 20,
  parameter int unsigned N_HLAYERS = 2,
  parameter int unsigned N_OUT     = 10,
  parameter int unsigned N_PE      = 10,
  parameter int unsigned AW        = 12,
  parameter int unsigned CW        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_IN*DW-1:0]    in_data,
  output logic                  w_rd,
  output logic [AW-1:0]         w_addr,
  input  logic [N_PE*DW-1:0]    w_data,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         class_out,
  output logic [N_OUT*DW-1:0]   scores
);

  localparam int unsigned KMAX  = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int unsigned NBUF  = (KMAX > N_OUT) ? KMAX : N_OUT;
  localparam int unsigned BIW   = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int unsigned KW    = $clog2(KMAX + 1);
  localparam int unsigned G_HID = (N_HID + N_PE - 1) / N_PE;
  localparam int unsigned G_OUT = (N_OUT + N_PE - 1) / N_PE;
  localparam int unsigned GMAX  = (G_HID > G_OUT) ? G_HID : G_OUT;
  localparam int unsigned GW    = (GMAX > 1) ? $clog2(GMAX) : 1;
  localparam int unsigned LW    = $clog2(N_HLAYERS + 1);
  localparam int unsigned JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_WB, S_ARGMAX, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [LW-1:0]            layer_q, layer_d;
  logic [GW-1:0]            grp_q, grp_d;
  logic [KW-1:0]            k_q, k_d;
  logic [AW-1:0]            w_addr_q, w_addr_d;
  logic                     w_rd_q, w_rd_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     sel_q, sel_d;
  logic                     mac_vld_q, mac_vld_d;
  logic                     mac_bias_q, mac_bias_d;
  logic [KW-1:0]            mac_k_q, mac_k_d;
  logic signed [ACC_W-1:0]  acc_q [N_PE];
  logic signed [ACC_W-1:0]  acc_d [N_PE];
  logic signed [DW-1:0]     act_q [2][NBUF];
  logic signed [DW-1:0]     act_d [2][NBUF];
  logic [JW-1:0]            j_q, j_d;
  logic signed [DW-1:0]     best_val_q, best_val_d;
  logic [CW-1:0]            best_idx_q, best_idx_d;
  logic [CW-1:0]            class_q, class_d;
  logic [N_OUT*DW-1:0]      scores_q, scores_d;

  logic                     last_c;
  logic [KW-1:0]            k_lim_c;
  logic [GW-1:0]            g_last_c;
  int unsigned              m_lim_c;

  // Rescale an accumulator to the activation format, optionally rectifying.
  function automatic logic signed [DW-1:0] sat_act(input logic signed [ACC_W-1:0] a,
                                                   input logic relu);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (relu && s[ACC_W-1])  return '0;
    if (s > SAT_HI)          return DW'(SAT_HI);
    if (s < SAT_LO)          return DW'(SAT_LO);
    return DW'(s);
  endfunction

  // Shape of the layer currently being computed
  always_comb begin
    last_c   = (layer_q == LW'(N_HLAYERS));
    k_lim_c  = (layer_q == '0) ? KW'(N_IN) : KW'(N_HID);
    g_last_c = last_c ? GW'(G_OUT - 1) : GW'(G_HID - 1);
    m_lim_c  = last_c ? N_OUT : N_HID;
  end

  always_comb begin
    logic                    clr;
    logic signed [DW-1:0]    wl;
    logic signed [DW-1:0]    av;
    logic signed [2*DW-1:0]  prod;
    int unsigned             idx;

    state_d    = state_q;
    layer_d    = layer_q;
    grp_d      = grp_q;
    k_d        = k_q;
    w_addr_d   = w_addr_q;
    w_rd_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sel_d      = sel_q;
    mac_vld_d  = w_rd_q;
    mac_bias_d = (k_q == k_lim_c);
    mac_k_d    = k_q;
    acc_d      = acc_q;
    act_d      = act_q;
    j_d        = j_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    scores_d   = scores_q;
    clr        = 1'b0;
    wl         = '0;
    av         = '0;
    prod       = '0;
    idx        = 0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          layer_d  = '0;
          grp_d    = '0;
          k_d      = '0;
          w_addr_d = '0;
          w_rd_d   = 1'b1;
          busy_d   = 1'b1;
          sel_d    = 1'b0;
          clr      = 1'b1;
          for (int k = 0; k < N_IN; k++) begin
            act_d[0][BIW'(k)] = in_data[k*DW +: DW];
          end
        end
      end

      S_ISSUE: begin
        if (k_q == k_lim_c) begin
          state_d = S_DRAIN;
        end else begin
          k_d      = k_q + KW'(1);
          w_addr_d = w_addr_q + AW'(1);
          w_rd_d   = 1'b1;
        end
      end

      S_DRAIN: state_d = S_WB;

      S_WB: begin
        for (int p = 0; p < N_PE; p++) begin
          idx = 32'(grp_q) * N_PE + 32'(p);
          if (idx < m_lim_c) begin
            act_d[~sel_q][BIW'(idx)] = sat_act(acc_q[p], !last_c);
          end
        end
        if (grp_q == g_last_c) begin
          sel_d = ~sel_q;
          grp_d = '0;
          if (last_c) begin
            state_d = S_ARGMAX;
            j_d     = '0;
          end else begin
            layer_d = layer_q + LW'(1);
          end
        end else begin
          grp_d = grp_q + GW'(1);
        end
        // Weight words are contiguous across groups and layers, so the address just keeps counting.
        if (!(grp_q == g_last_c && last_c)) begin
          state_d  = S_ISSUE;
          k_d      = '0;
          w_addr_d = w_addr_q + AW'(1);
          w_rd_d   = 1'b1;
          clr      = 1'b1;
        end
      end

      S_ARGMAX: begin
        av = act_q[sel_q][BIW'(j_q)];
        if (j_q == '0 || av > best_val_q) begin
          best_val_d = av;
          best_idx_d = CW'(j_q);
        end
        if (j_q == JW'(N_OUT - 1)) begin
          state_d = S_DONE;
        end else begin
          j_d = j_q + JW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        class_d = best_idx_q;
        for (int j = 0; j < N_OUT; j++) begin
          scores_d[j*DW +: DW] = act_q[sel_q][BIW'(j)];
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Lanes consume the word read on the previous cycle
    for (int p = 0; p < N_PE; p++) begin
      wl   = w_data[p*DW +: DW];
      av   = act_q[sel_q][BIW'(mac_k_q)];
      prod = av * wl;
      if (clr) begin
        acc_d[p] = '0;
      end else if (mac_vld_q) begin
        if (mac_bias_q) acc_d[p] = acc_q[p] + (ACC_W'(wl) <<< FRAC);
        else            acc_d[p] = acc_q[p] + ACC_W'(prod);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      layer_q    <= '0;
      grp_q      <= '0;
      k_q        <= '0;
      w_addr_q   <= '0;
      w_rd_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_q      <= 1'b0;
      mac_vld_q  <= 1'b0;
      mac_bias_q <= 1'b0;
      mac_k_q    <= '0;
      acc_q      <= '{default: '0};
      act_q      <= '{default: '{default: '0}};
      j_q        <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      scores_q   <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      grp_q      <= grp_d;
      k_q        <= k_d;
      w_addr_q   <= w_addr_d;
      w_rd_q     <= w_rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sel_q      <= sel_d;
      mac_vld_q  <= mac_vld_d;
      mac_bias_q <= mac_bias_d;
      mac_k_q    <= mac_k_d;
      acc_q      <= acc_d;
      act_q      <= act_d;
      j_q        <= j_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
      scores_q   <= scores_d;
    end
  end

  assign w_rd      = w_rd_q;
  assign w_addr    = w_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign class_out = class_q;
  assign scores    = scores_q;

endmodule
